// File: rtl/digital_monitor_ctr.sv
// digital_monitor_ctr
//   Routes one per-channel (vector) or chip-global (scalar) digital signal to
//   the digital monitor pad. The selected signal can go out directly, as a
//   stretched pulse, as a toggle or as a sticky flag. A saturating counter
//   counts its rising edges for read-back through configuration.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high reset
//   monitor_enable  enables the output stage and the event counter
//   monitor_select  source select (vector sources first, then scalar sources)
//   monitor_chan    channel select for vector sources
//   monitor_mode    00 direct, 01 stretch, 10 toggle, 11 sticky
//   stretch_len     extra high cycles in stretch mode
//   count_clear     clears event_count, count_overflow and the sticky flag
//   vec_src         source s, channel c at bit s*NUM_CHANNELS+c
//   scl_src         scalar sources
//   digital_monitor registered monitor output
//   event_count     saturating count of rising edges on the selected signal
//   count_overflow  sticky saturation flag
module digital_monitor_ctr #(
  parameter int NUM_CHANNELS = 64,
  parameter int CHAN_W       = $clog2(NUM_CHANNELS),
  parameter int NUM_VEC_SRC  = 7,
  parameter int NUM_SCL_SRC  = 4,
  parameter int SEL_W        = 4,
  parameter int STRETCH_W    = 4,
  parameter int CNT_W        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                monitor_enable,
  input  logic [SEL_W-1:0]                    monitor_select,
  input  logic [CHAN_W-1:0]                   monitor_chan,
  input  logic [1:0]                          monitor_mode,
  input  logic [STRETCH_W-1:0]                stretch_len,
  input  logic                                count_clear,
  input  logic [NUM_VEC_SRC*NUM_CHANNELS-1:0] vec_src,
  input  logic [NUM_SCL_SRC-1:0]              scl_src,
  output logic                                digital_monitor,
  output logic [CNT_W-1:0]                    event_count,
  output logic                                count_overflow
);

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_STRETCH = 2'b01,
    MODE_TOGGLE  = 2'b10,
    MODE_STICKY  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Source mux built as an AND-OR tree: each source bit is gated by its own
  // select/channel decode. Unused select codes and out-of-range channels
  // match no term, so the mux output is 0 for them.
  logic [NUM_VEC_SRC*NUM_CHANNELS-1:0] vec_hit;
  logic [NUM_SCL_SRC-1:0]              scl_hit;
  logic                                mux_out;

  for (genvar gi = 0; gi < NUM_VEC_SRC; gi++) begin : g_vec_src
    for (genvar gj = 0; gj < NUM_CHANNELS; gj++) begin : g_vec_chan
      assign vec_hit[gi*NUM_CHANNELS+gj] = vec_src[gi*NUM_CHANNELS+gj]
                                           & (monitor_select == SEL_W'(gi))
                                           & (monitor_chan == CHAN_W'(gj));
    end
  end

  for (genvar gi = 0; gi < NUM_SCL_SRC; gi++) begin : g_scl_src
    assign scl_hit[gi] = scl_src[gi] & (monitor_select == SEL_W'(NUM_VEC_SRC + gi));
  end

  assign mux_out = (|vec_hit) | (|scl_hit);

  // State
  logic                 s1_q, s1d_q, blank_q;
  logic [SEL_W-1:0]     sel_prev_q;
  logic [CHAN_W-1:0]    chan_prev_q;
  logic [1:0]           mode_prev_q;
  logic                 dm_q, dm_d;
  logic [STRETCH_W-1:0] scnt_q, scnt_d;
  logic                 tog_q, tog_d;
  logic                 stk_q, stk_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic rise, cfg_change, mode_change;

  // cfg_change is seen in the cycle the new select/chan is applied; it is
  // registered into blank_q on the same edge that s1 captures the first
  // sample of the new source, so that sample can never look like an edge.
  assign cfg_change  = (monitor_select != sel_prev_q) || (monitor_chan != chan_prev_q);
  assign mode_change = (monitor_mode != mode_prev_q);
  assign rise        = s1_q & ~s1d_q & ~blank_q;

  // Output stage next state. dm takes the updated toggle/sticky value so
  // that every mode responds two cycles after the input.
  always_comb begin
    scnt_d = scnt_q;
    tog_d  = tog_q;
    stk_d  = stk_q;
    dm_d   = 1'b0;
    if (!monitor_enable || mode_change) begin
      scnt_d = '0;
      tog_d  = 1'b0;
      stk_d  = 1'b0;
    end else begin
      case (mode_e'(monitor_mode))
        MODE_DIRECT: dm_d = s1_q;
        MODE_STRETCH: begin
          if (rise) begin
            dm_d   = 1'b1;
            scnt_d = stretch_len;
          end else if (scnt_q != '0) begin
            dm_d   = 1'b1;
            scnt_d = scnt_q - STRETCH_W'(1);
          end
        end
        MODE_TOGGLE: begin
          if (rise) tog_d = ~tog_q;
          dm_d = tog_d;
        end
        MODE_STICKY: begin
          if (rise) stk_d = 1'b1;
          if (count_clear) stk_d = 1'b0;
          dm_d = stk_d;
        end
        default: dm_d = 1'b0;
      endcase
    end
    if (count_clear) stk_d = 1'b0;
  end

  // Saturating event counter; a clear beats a coincident edge.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (count_clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (monitor_enable && rise) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s1d_q       <= 1'b0;
      blank_q     <= 1'b0;
      sel_prev_q  <= '0;
      chan_prev_q <= '0;
      mode_prev_q <= '0;
      dm_q        <= 1'b0;
      scnt_q      <= '0;
      tog_q       <= 1'b0;
      stk_q       <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      // s1/s1d track even while disabled so re-enabling sees no false edge.
      s1_q        <= mux_out;
      s1d_q       <= s1_q;
      blank_q     <= cfg_change;
      sel_prev_q  <= monitor_select;
      chan_prev_q <= monitor_chan;
      mode_prev_q <= monitor_mode;
      dm_q        <= dm_d;
      scnt_q      <= scnt_d;
      tog_q       <= tog_d;
      stk_q       <= stk_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign digital_monitor = dm_q;
  assign event_count     = cnt_q;
  assign count_overflow  = ovf_q;

endmodule

// File: tb/tb_digital_monitor_ctr.sv
// Testbench for digital_monitor_ctr (CNT_W=4 so saturation is reachable).
// Stimulus pushes expected outputs, stamped with the cycle they are due,
// onto a scoreboard queue; a negedge monitor pops and compares them.
module tb_digital_monitor_ctr;

  localparam int NCH  = 64;
  localparam int CHW  = 6;
  localparam int NVEC = 7;
  localparam int NSCL = 4;
  localparam int SELW = 4;
  localparam int SLW  = 4;
  localparam int CW   = 4;

  localparam int K_DM  = 0;
  localparam int K_CNT = 1;
  localparam int K_OVF = 2;

  localparam int B_A = 2*NCH + 37;  // source 2, channel 37
  localparam int B_B = 2*NCH + 5;   // source 2, channel 5

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 monitor_enable;
  logic [SELW-1:0]      monitor_select;
  logic [CHW-1:0]       monitor_chan;
  logic [1:0]           monitor_mode;
  logic [SLW-1:0]       stretch_len;
  logic                 count_clear;
  logic [NVEC*NCH-1:0]  vec_src;
  logic [NSCL-1:0]      scl_src;
  logic                 digital_monitor;
  logic [CW-1:0]        event_count;
  logic                 count_overflow;

  digital_monitor_ctr #(
    .NUM_CHANNELS(NCH), .CHAN_W(CHW), .NUM_VEC_SRC(NVEC), .NUM_SCL_SRC(NSCL),
    .SEL_W(SELW), .STRETCH_W(SLW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .monitor_enable(monitor_enable),
    .monitor_select(monitor_select), .monitor_chan(monitor_chan),
    .monitor_mode(monitor_mode), .stretch_len(stretch_len),
    .count_clear(count_clear), .vec_src(vec_src), .scl_src(scl_src),
    .digital_monitor(digital_monitor), .event_count(event_count),
    .count_overflow(count_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string tag;
    int    due;
    int    kind;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  bit dir_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) begin
      n_pass++;
      $display("check %-10s cyc %0d: got %0d", tag, cyc, obs);
    end else begin
      $display("FAIL %s cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic expect_at(input string tag, input int dly, input int kind, input int val);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_bit(input int idx, input bit v);
    logic [NVEC*NCH-1:0] m;
    m    = '0;
    m[0] = 1'b1;
    m    = m << idx;
    if (v) vec_src = vec_src | m;
    else   vec_src = vec_src & ~m;
  endtask

  task automatic pulse(input int idx);
    set_bit(idx, 1'b1);
    tick(1);
    set_bit(idx, 1'b0);
    tick(1);
  endtask

  task automatic clear_count();
    count_clear = 1'b1;
    tick(1);
    count_clear = 1'b0;
    tick(2);
  endtask

  // Scoreboard monitor: compare every entry due this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        case (sb_q[i].kind)
          K_DM:    chk(sb_q[i].tag, int'(digital_monitor), sb_q[i].val);
          K_CNT:   chk(sb_q[i].tag, int'(event_count), sb_q[i].val);
          default: chk(sb_q[i].tag, int'(count_overflow), sb_q[i].val);
        endcase
        sb_q.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1; monitor_enable = 1'b0; monitor_select = '0; monitor_chan = '0;
    monitor_mode = 2'b00; stretch_len = '0; count_clear = 1'b0;
    vec_src = '0; scl_src = '0;
    tick(2);
    expect_at("rst_dm", 1, K_DM, 0);
    expect_at("rst_cnt", 1, K_CNT, 0);
    expect_at("rst_ovf", 1, K_OVF, 0);
    tick(1);

    // Direct mode: two-cycle latency mirror
    reset = 1'b0; monitor_enable = 1'b1; monitor_select = 4'd2; monitor_chan = 6'd37;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      set_bit(B_A, dir_pat[i]);
      expect_at("direct", 2, K_DM, int'(dir_pat[i]));
      tick(1);
    end
    expect_at("dir_cnt", 1, K_CNT, 3);
    tick(1);
    set_bit(B_A, 1'b1); monitor_select = 4'd15;
    expect_at("sel15", 2, K_DM, 0);
    expect_at("sel15", 3, K_DM, 0);
    tick(4);

    // Scalar range boundaries and an unused select code
    monitor_select = 4'd7; scl_src = 4'b0001;
    expect_at("scl_first", 3, K_DM, 1);
    tick(4);
    monitor_select = 4'd10; scl_src = 4'b1000;
    expect_at("scl_last", 3, K_DM, 1);
    tick(4);
    monitor_select = 4'd11;
    expect_at("sel11", 2, K_DM, 0);
    expect_at("resel_cnt", 2, K_CNT, 3);
    tick(3);

    // Stretch mode: single pulse, then retriggered pair
    monitor_select = 4'd2; monitor_chan = 6'd37; set_bit(B_A, 1'b0); scl_src = '0;
    monitor_mode = 2'b01; stretch_len = 4'd3;
    clear_count();
    tick(1);
    for (int d = 1; d <= 7; d++) expect_at("stretch1", d, K_DM, int'(d >= 2 && d <= 5));
    pulse(B_A);
    tick(6);
    count_clear = 1'b1;
    expect_at("clr_cnt", 1, K_CNT, 0);
    tick(1);
    count_clear = 1'b0;
    tick(2);
    for (int d = 1; d <= 9; d++) expect_at("stretch2", d, K_DM, int'(d >= 2 && d <= 7));
    pulse(B_A);
    pulse(B_A);
    tick(8);
    expect_at("stretch_cnt", 1, K_CNT, 2);
    tick(1);

    // Toggle mode: five pulses
    monitor_mode = 2'b10;
    clear_count();
    for (int i = 0; i < 5; i++) begin
      expect_at("toggle", 3, K_DM, (i + 1) % 2);
      pulse(B_A);
      tick(1);
    end
    expect_at("tog_end", 1, K_DM, 1);
    expect_at("tog_cnt", 1, K_CNT, 5);
    tick(2);

    // Sticky mode: holds until count_clear
    monitor_mode = 2'b11;
    clear_count();
    expect_at("stk_pre", 1, K_DM, 0);
    expect_at("sticky", 2, K_DM, 1);
    expect_at("sticky", 5, K_DM, 1);
    expect_at("sticky", 10, K_DM, 1);
    expect_at("stk_cnt", 10, K_CNT, 1);
    pulse(B_A);
    tick(9);
    count_clear = 1'b1;
    expect_at("stk_clr", 1, K_DM, 0);
    expect_at("stk_clr_cnt", 1, K_CNT, 0);
    tick(1);
    count_clear = 1'b0;
    expect_at("stk_clr", 2, K_DM, 0);
    tick(3);

    // Reselect from held-low to held-high channel is not an event
    monitor_mode = 2'b00; set_bit(B_B, 1'b1);
    clear_count();
    monitor_chan = 6'd5;
    expect_at("resel_dm", 3, K_DM, 1);
    expect_at("resel_nocnt", 4, K_CNT, 0);
    tick(5);
    set_bit(B_B, 1'b0);
    tick(2);
    set_bit(B_B, 1'b1);
    expect_at("newchan_cnt", 3, K_CNT, 1);
    tick(4);

    // Saturation at 15, then clear coincident with an edge
    monitor_chan = 6'd37; set_bit(B_B, 1'b0);
    clear_count();
    for (int i = 0; i < 15; i++) pulse(B_A);
    expect_at("cnt15", 2, K_CNT, 15);
    expect_at("ovf15", 2, K_OVF, 0);
    tick(2);
    pulse(B_A);
    pulse(B_A);
    expect_at("sat_cnt", 2, K_CNT, 15);
    expect_at("sat_ovf", 2, K_OVF, 1);
    tick(2);
    expect_at("clredge_cnt", 2, K_CNT, 0);
    expect_at("clredge_ovf", 2, K_OVF, 0);
    expect_at("clredge_cnt", 4, K_CNT, 0);
    expect_at("clredge_ovf", 4, K_OVF, 0);
    set_bit(B_A, 1'b1);
    tick(1);
    count_clear = 1'b1; set_bit(B_A, 1'b0);
    tick(1);
    count_clear = 1'b0;
    tick(4);

    // Reset during a stretched pulse with count 7
    monitor_mode = 2'b01; stretch_len = 4'd15;
    tick(3);
    for (int i = 0; i < 7; i++) pulse(B_A);
    expect_at("pre_rst_cnt", 1, K_CNT, 7);
    expect_at("pre_rst_dm", 1, K_DM, 1);
    tick(1);
    reset = 1'b1;
    expect_at("midrst_dm", 1, K_DM, 0);
    expect_at("midrst_cnt", 1, K_CNT, 0);
    expect_at("midrst_ovf", 1, K_OVF, 0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Disable: output forced low, count holds, no false edge on re-enable
    monitor_mode = 2'b00;
    tick(2);
    pulse(B_A);
    pulse(B_A);
    expect_at("en_cnt", 1, K_CNT, 2);
    tick(1);
    monitor_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_at("dis_dm", 1, K_DM, 0);
      expect_at("dis_dm", 2, K_DM, 0);
      pulse(B_A);
    end
    expect_at("dis_cnt", 1, K_CNT, 2);
    set_bit(B_A, 1'b1);
    tick(3);
    monitor_enable = 1'b1;
    expect_at("reen_dm", 2, K_DM, 1);
    expect_at("reen_cnt", 3, K_CNT, 2);
    tick(5);

    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
